alu_issue_sched: RTL and testbench

//  Issue scheduler for the dual-lane ALU block (two alu_sub lanes feeding the LSQ address selector).

---
 rtl/alu_sched_pkg.sv | 23 ++
 rtl/alu_sched_select.sv | 37 +++
 rtl/alu_issue_sched.sv | 233 +++++++++++++++++++++++
 tb/tb_alu_issue_sched.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared constants and helpers for the ALU issue scheduler.
package alu_sched_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // Queue entry layout (LSB first) for the default widths: 32b operands, 17b op_func, 4b tags.
    localparam int unsigned ENT_DTAG_OFF  = 0;
    localparam int unsigned ENT_SRC2_OFF  = ENT_DTAG_OFF + 4;
    localparam int unsigned ENT_STAG2_OFF = ENT_SRC2_OFF + 32;
    localparam int unsigned ENT_RDY2_OFF  = ENT_STAG2_OFF + 4;
    localparam int unsigned ENT_SRC1_OFF  = ENT_RDY2_OFF + 1;
    localparam int unsigned ENT_STAG1_OFF = ENT_SRC1_OFF + 32;
    localparam int unsigned ENT_RDY1_OFF  = ENT_STAG1_OFF + 4;
    localparam int unsigned ENT_FUNC_OFF  = ENT_RDY1_OFF + 1;
    localparam int unsigned ENT_VLD_OFF   = ENT_FUNC_OFF + 17;
    localparam int unsigned ENT_WIDTH     = ENT_VLD_OFF + 1;

    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    endfunction

endpackage

// File: rtl/alu_sched_select.sv
// Find-first-two-ready selector: oldest ready entry to lane 1, next eligible to lane 2,
// with at most one memory op granted per cycle.
module alu_sched_select
    import alu_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic [DEPTH-1:0]      ready_i,
    input  logic [DEPTH-1:0][6:0] opcode_i,
    output logic [DEPTH-1:0]      gnt1_o,
    output logic [DEPTH-1:0]      gnt2_o
);

    logic found1, found2, mem_taken;

    always_comb begin
        gnt1_o    = '0;
        gnt2_o    = '0;
        found1    = 1'b0;
        found2    = 1'b0;
        mem_taken = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready_i[i]) begin
                if (!found1) begin
                    gnt1_o[i] = 1'b1;
                    found1    = 1'b1;
                    mem_taken = is_mem_op(opcode_i[i]);
                end else if (!found2 && !(mem_taken && is_mem_op(opcode_i[i]))) begin
                    // A second mem candidate is skipped so a younger non-mem op can use lane 2.
                    gnt2_o[i] = 1'b1;
                    found2    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_issue_sched.sv
// Dual-lane ALU issue scheduler: collapsing queue with CDB wakeup and registered lane ports.
// Optional ALU_SCHED_PERF_CNT_EN adds issued-op and enqueue-stall counters.
module alu_issue_sched
    import alu_sched_pkg::*;
#(
    parameter int unsigned OPRAND_WIDTH  = 32,
    parameter int unsigned OP_FUNC_WIDTH = 17,
    parameter int unsigned TAG_WIDTH     = 4,
    parameter int unsigned DEPTH         = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     enq_valid_i,
    output logic                     enq_ready_o,
    input  logic [OP_FUNC_WIDTH-1:0] enq_op_func_i,
    input  logic [OPRAND_WIDTH-1:0]  enq_src1_i,
    input  logic [OPRAND_WIDTH-1:0]  enq_src2_i,
    input  logic                     enq_rdy1_i,
    input  logic                     enq_rdy2_i,
    input  logic [TAG_WIDTH-1:0]     enq_stag1_i,
    input  logic [TAG_WIDTH-1:0]     enq_stag2_i,
    input  logic [TAG_WIDTH-1:0]     enq_dtag_i,
    output logic                     iss1_valid_o,
    output logic                     iss2_valid_o,
    output logic [OPRAND_WIDTH-1:0]  operand11_o,
    output logic [OPRAND_WIDTH-1:0]  operand12_o,
    output logic [OPRAND_WIDTH-1:0]  operand21_o,
    output logic [OPRAND_WIDTH-1:0]  operand22_o,
    output logic [OP_FUNC_WIDTH-1:0] op_func1_o,
    output logic [OP_FUNC_WIDTH-1:0] op_func2_o,
    output logic [TAG_WIDTH-1:0]     iss1_dtag_o,
    output logic [TAG_WIDTH-1:0]     iss2_dtag_o,
    input  logic [OPRAND_WIDTH-1:0]  result1_i,
    input  logic [OPRAND_WIDTH-1:0]  result2_i,
    input  logic                     ext_valid_i,
    input  logic [TAG_WIDTH-1:0]     ext_tag_i,
    input  logic [OPRAND_WIDTH-1:0]  ext_data_i
`ifdef ALU_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]              perf_issued_o,
    output logic [31:0]              perf_stall_o
`endif
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic                     vld;
        logic [OP_FUNC_WIDTH-1:0] func;
        logic                     rdy1;
        logic [TAG_WIDTH-1:0]     stag1;
        logic [OPRAND_WIDTH-1:0]  src1;
        logic                     rdy2;
        logic [TAG_WIDTH-1:0]     stag2;
        logic [OPRAND_WIDTH-1:0]  src2;
        logic [TAG_WIDTH-1:0]     dtag;
    } entry_t;

    entry_t ent_q [DEPTH];
    entry_t ent_d [DEPTH];
    entry_t ent_w [DEPTH];
    entry_t enq_w, sel1, sel2;

    logic                      iss1_valid_q, iss2_valid_q;
    logic [OP_FUNC_WIDTH-1:0]  func1_q, func2_q;
    logic [OPRAND_WIDTH-1:0]   opnd11_q, opnd12_q, opnd21_q, opnd22_q;
    logic [TAG_WIDTH-1:0]      dtag1_q, dtag2_q;

    logic [DEPTH-1:0]          rdy_vec, gnt1, gnt2;
    logic [DEPTH-1:0][6:0]     opc;
    logic [CntW-1:0]           cnt;
    logic [IdxW-1:0]           wr_idx;
    logic                      any_gnt1, any_gnt2, enq_fire;

    // Wakeup bus: lane 1, lane 2, external CDB.
    logic [2:0]                bus_v;
    logic [3*TAG_WIDTH-1:0]    bus_t;
    logic [3*OPRAND_WIDTH-1:0] bus_d;

    assign bus_v = {ext_valid_i, iss2_valid_q, iss1_valid_q};
    assign bus_t = {ext_tag_i, dtag2_q, dtag1_q};
    assign bus_d = {ext_data_i, result2_i, result1_i};

    function automatic entry_t wake(input entry_t e, input logic [2:0] bv,
                                    input logic [3*TAG_WIDTH-1:0] bt,
                                    input logic [3*OPRAND_WIDTH-1:0] bd);
        entry_t r = e;
        for (int k = 0; k < 3; k++) begin
            if (bv[k] && !e.rdy1 && bt[k*TAG_WIDTH +: TAG_WIDTH] == e.stag1) begin
                r.rdy1 = 1'b1;
                r.src1 = bd[k*OPRAND_WIDTH +: OPRAND_WIDTH];
            end
            if (bv[k] && !e.rdy2 && bt[k*TAG_WIDTH +: TAG_WIDTH] == e.stag2) begin
                r.rdy2 = 1'b1;
                r.src2 = bd[k*OPRAND_WIDTH +: OPRAND_WIDTH];
            end
        end
        return r;
    endfunction

    always_comb begin
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rdy_vec[i] = ent_q[i].vld & ent_q[i].rdy1 & ent_q[i].rdy2;
            opc[i]     = ent_q[i].func[6:0];
            ent_w[i]   = wake(ent_q[i], bus_v, bus_t, bus_d);
            cnt        = cnt + CntW'(ent_q[i].vld);
        end
    end

    alu_sched_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .ready_i  (rdy_vec),
        .opcode_i (opc),
        .gnt1_o   (gnt1),
        .gnt2_o   (gnt2)
    );

    assign any_gnt1    = |gnt1;
    assign any_gnt2    = |gnt2;
    assign enq_ready_o = (cnt < CntW'(DEPTH)) | any_gnt1;
    assign enq_fire    = enq_valid_i & enq_ready_o & ~flush_i;

    always_comb begin
        enq_w       = '0;
        enq_w.vld   = 1'b1;
        enq_w.func  = enq_op_func_i;
        enq_w.rdy1  = enq_rdy1_i;
        enq_w.stag1 = enq_stag1_i;
        enq_w.src1  = enq_src1_i;
        enq_w.rdy2  = enq_rdy2_i;
        enq_w.stag2 = enq_stag2_i;
        enq_w.src2  = enq_src2_i;
        enq_w.dtag  = enq_dtag_i;
        enq_w       = wake(enq_w, bus_v, bus_t, bus_d);
    end

    // Compact survivors toward index 0, then append the new op behind them.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
        wr_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].vld && !gnt1[i] && !gnt2[i]) begin
                ent_d[wr_idx] = ent_w[i];
                wr_idx        = wr_idx + 1'b1;
            end
        end
        if (enq_fire) ent_d[wr_idx] = enq_w;
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
        end
    end

    always_comb begin
        sel1 = '0;
        sel2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (gnt1[i]) sel1 = ent_q[i];
            if (gnt2[i]) sel2 = ent_q[i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            iss1_valid_q <= 1'b0;
            iss2_valid_q <= 1'b0;
            func1_q      <= '0;
            func2_q      <= '0;
            opnd11_q     <= '0;
            opnd12_q     <= '0;
            opnd21_q     <= '0;
            opnd22_q     <= '0;
            dtag1_q      <= '0;
            dtag2_q      <= '0;
        end else begin
            iss1_valid_q <= any_gnt1 & ~flush_i;
            iss2_valid_q <= any_gnt2 & ~flush_i;
            if (any_gnt1 && !flush_i) begin
                func1_q  <= sel1.func;
                opnd11_q <= sel1.src1;
                opnd12_q <= sel1.src2;
                dtag1_q  <= sel1.dtag;
            end
            if (any_gnt2 && !flush_i) begin
                func2_q  <= sel2.func;
                opnd21_q <= sel2.src1;
                opnd22_q <= sel2.src2;
                dtag2_q  <= sel2.dtag;
            end
        end
    end

    assign iss1_valid_o = iss1_valid_q;
    assign iss2_valid_o = iss2_valid_q;
    assign op_func1_o   = func1_q;
    assign op_func2_o   = func2_q;
    assign operand11_o  = opnd11_q;
    assign operand12_o  = opnd12_q;
    assign operand21_o  = opnd21_q;
    assign operand22_o  = opnd22_q;
    assign iss1_dtag_o  = dtag1_q;
    assign iss2_dtag_o  = dtag2_q;

`ifdef ALU_SCHED_PERF_CNT_EN
    logic [31:0] perf_issued_q, perf_stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (!flush_i) perf_issued_q <= perf_issued_q + 32'(any_gnt1) + 32'(any_gnt2);
            if (enq_valid_i && !enq_ready_o) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_issued_o = perf_issued_q;
    assign perf_stall_o  = perf_stall_q;
`else
`endif

endmodule

// File: tb/tb_alu_issue_sched.sv
// Scoreboard bench for alu_issue_sched: directed stimulus, expected issues queued, lane monitor.
module tb_alu_issue_sched;

    localparam logic [16:0] ADD  = 17'h00033;
    localparam logic [16:0] LOAD = 17'h00003;

    typedef struct {
        int          lane;
        logic [16:0] func;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  dtag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, enq_valid, enq_ready;
    logic [16:0] enq_func;
    logic [31:0] enq_src1, enq_src2;
    logic        enq_rdy1, enq_rdy2;
    logic [3:0]  enq_stag1, enq_stag2, enq_dtag;
    logic        iss1_valid, iss2_valid;
    logic [31:0] opnd11, opnd12, opnd21, opnd22;
    logic [16:0] func1, func2;
    logic [3:0]  dtag1, dtag2;
    logic [31:0] result1, result2;
    logic        ext_valid;
    logic [3:0]  ext_tag;
    logic [31:0] ext_data;
`ifdef ALU_SCHED_PERF_CNT_EN
    logic [31:0] perf_issued, perf_stall;
`endif

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_issue_sched u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .enq_valid_i   (enq_valid),
        .enq_ready_o   (enq_ready),
        .enq_op_func_i (enq_func),
        .enq_src1_i    (enq_src1),
        .enq_src2_i    (enq_src2),
        .enq_rdy1_i    (enq_rdy1),
        .enq_rdy2_i    (enq_rdy2),
        .enq_stag1_i   (enq_stag1),
        .enq_stag2_i   (enq_stag2),
        .enq_dtag_i    (enq_dtag),
        .iss1_valid_o  (iss1_valid),
        .iss2_valid_o  (iss2_valid),
        .operand11_o   (opnd11),
        .operand12_o   (opnd12),
        .operand21_o   (opnd21),
        .operand22_o   (opnd22),
        .op_func1_o    (func1),
        .op_func2_o    (func2),
        .iss1_dtag_o   (dtag1),
        .iss2_dtag_o   (dtag2),
        .result1_i     (result1),
        .result2_i     (result2),
        .ext_valid_i   (ext_valid),
        .ext_tag_i     (ext_tag),
        .ext_data_i    (ext_data)
`ifdef ALU_SCHED_PERF_CNT_EN
        ,
        .perf_issued_o (perf_issued),
        .perf_stall_o  (perf_stall)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic push(input int lane, input logic [16:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] t);
        exp_t e;
        e.lane = lane; e.func = f; e.a = a; e.b = b; e.dtag = t;
        exp_q.push_back(e);
    endtask

    task automatic check_lane(input int lane, input logic [16:0] f, input logic [31:0] a,
                              input logic [31:0] b, input logic [3:0] t);
        exp_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL issue_unexpected: lane%0d func=%h a=%0d b=%0d dtag=%0d, expected none",
                     lane, f, a, b, t);
        end else begin
            e = exp_q.pop_front();
            if (e.lane != lane || e.func !== f || e.a !== a || e.b !== b || e.dtag !== t) begin
                n_fail++;
                $display("FAIL issue_lane%0d: got lane=%0d func=%h a=%0d b=%0d dtag=%0d, expected lane=%0d func=%h a=%0d b=%0d dtag=%0d",
                         lane, lane, f, a, b, t, e.lane, e.func, e.a, e.b, e.dtag);
            end
        end
    endtask

    // Monitor: every valid lane output is checked against the next expected issue.
    always @(negedge clk) begin
        if (!rst) begin
            if (iss1_valid) check_lane(1, func1, opnd11, opnd12, dtag1);
            if (iss2_valid) check_lane(2, func2, opnd21, opnd22, dtag2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_enq(input logic [16:0] f, input logic [31:0] s1, input logic r1,
                           input logic [3:0] t1, input logic [31:0] s2, input logic r2,
                           input logic [3:0] t2, input logic [3:0] d);
        enq_func = f; enq_src1 = s1; enq_rdy1 = r1; enq_stag1 = t1;
        enq_src2 = s2; enq_rdy2 = r2; enq_stag2 = t2; enq_dtag = d;
    endtask

    task automatic enq(input logic [16:0] f, input logic [31:0] s1, input logic r1,
                       input logic [3:0] t1, input logic [31:0] s2, input logic r2,
                       input logic [3:0] t2, input logic [3:0] d);
        set_enq(f, s1, r1, t1, s2, r2, t2, d);
        enq_valid = 1'b1;
        tick();
        enq_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; enq_valid = 1'b0;
        set_enq('0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
        result1 = '0; result2 = '0;
        ext_valid = 1'b0; ext_tag = '0; ext_data = '0;
        #12 rst = 1'b0;
        #1;

        // Reset state
        chk("rst_iss1_valid", 32'(iss1_valid), 0);
        chk("rst_iss2_valid", 32'(iss2_valid), 0);
        chk("rst_enq_ready", 32'(enq_ready), 1);
        chk("rst_operand11", opnd11, 0);
        chk("rst_op_func1", 32'(func1), 0);
        chk("rst_iss2_dtag", 32'(dtag2), 0);

        // 1: single ready ADD issues on lane 1 one edge after enqueue
        push(1, ADD, 5, 7, 1);
        enq(ADD, 5, 1'b1, 0, 7, 1'b1, 0, 1);
        chk("t1_not_same_cycle", 32'(iss1_valid), 0);
        tick();
        chk("t1_iss1_valid", 32'(iss1_valid), 1);
        chk("t1_iss2_idle", 32'(iss2_valid), 0);

        // 2: B waits on A's tag and picks up lane 1 result two cycles later
        result1 = 32'd12;
        push(1, ADD, 1, 2, 3);
        push(1, ADD, 12, 4, 5);
        enq(ADD, 1, 1'b1, 0, 2, 1'b1, 0, 3);
        enq(ADD, 0, 1'b0, 3, 4, 1'b1, 0, 5);
        chk("t2_a_issue_dtag", 32'(iss1_valid ? dtag1 : 4'hf), 3);
        tick();
        chk("t2_gap_idle", 32'(iss1_valid), 0);
        tick();
        chk("t2_b_issue_dtag", 32'(iss1_valid ? dtag1 : 4'hf), 5);

        // 3: full queue of waiting ops, ext wake of entry 2, blocked op then accepted
        for (int i = 0; i < 8; i++) enq(ADD, 0, 1'b0, 4'(8 + i), 32'(100 + i), 1'b1, 0, 4'(i));
        chk("t3_full_not_ready", 32'(enq_ready), 0);
        set_enq(ADD, 9, 1'b1, 0, 9, 1'b1, 0, 12);
        enq_valid = 1'b1;
        ext_valid = 1'b1; ext_tag = 4'd10; ext_data = 32'd77;
        push(1, ADD, 77, 102, 2);
        push(1, ADD, 9, 9, 12);
        tick();
        ext_valid = 1'b0;
        chk("t3_ready_on_issue", 32'(enq_ready), 1);
        tick();
        enq_valid = 1'b0;
        chk("t3_entry2_issue", 32'(iss1_valid ? dtag1 : 4'hf), 2);
        tick();
        chk("t3_freed_slot_issue", 32'(iss1_valid ? dtag1 : 4'hf), 12);
`ifdef ALU_SCHED_PERF_CNT_EN
        chk("t3_perf_stall", perf_stall, 1);
        chk("t3_perf_issued", perf_issued, 5);
`endif
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_flush_ready", 32'(enq_ready), 1);
        chk("t3_flush_no_issue", 32'(iss1_valid), 0);

        // 4: two loads and an ADD woken together; second load deferred
        enq(LOAD, 0, 1'b0, 15, 1, 1'b1, 0, 6);
        enq(LOAD, 0, 1'b0, 15, 2, 1'b1, 0, 7);
        enq(ADD, 0, 1'b0, 15, 3, 1'b1, 0, 8);
        push(1, LOAD, 50, 1, 6);
        push(2, ADD, 50, 3, 8);
        push(1, LOAD, 50, 2, 7);
        ext_valid = 1'b1; ext_tag = 4'd15; ext_data = 32'd50;
        tick();
        ext_valid = 1'b0;
        tick();
        chk("t4_c1_lane1", 32'(iss1_valid ? dtag1 : 4'hf), 6);
        chk("t4_c1_lane2", 32'(iss2_valid ? dtag2 : 4'hf), 8);
        tick();
        chk("t4_c2_lane1", 32'(iss1_valid ? dtag1 : 4'hf), 7);
        chk("t4_c2_lane2_idle", 32'(iss2_valid), 0);

        // 5: four ready ops flushed before issue; concurrent enqueue dropped
        for (int i = 0; i < 4; i++) enq(ADD, 0, 1'b0, 14, 32'(i), 1'b1, 0, 4'(9 + i));
        ext_valid = 1'b1; ext_tag = 4'd14; ext_data = 32'd1;
        tick();
        ext_valid = 1'b0;
        flush = 1'b1;
        set_enq(ADD, 1, 1'b1, 0, 1, 1'b1, 0, 4);
        enq_valid = 1'b1;
        tick();
        flush = 1'b0;
        enq_valid = 1'b0;
        chk("t5_iss1_killed", 32'(iss1_valid), 0);
        chk("t5_iss2_killed", 32'(iss2_valid), 0);
        chk("t5_enq_ready", 32'(enq_ready), 1);
        tick();
        tick();
        chk("t5_queue_empty", 32'(iss1_valid), 0);

        // 6: asynchronous reset while lane 1 holds an op
        push(1, ADD, 3, 4, 13);
        enq(ADD, 3, 1'b1, 0, 4, 1'b1, 0, 13);
        tick();
        chk("t6_pre_reset_valid", 32'(iss1_valid), 1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t6_async_iss1", 32'(iss1_valid), 0);
        chk("t6_async_operand11", opnd11, 0);
        chk("t6_async_dtag1", 32'(dtag1), 0);
        chk("t6_async_enq_ready", 32'(enq_ready), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        tick();
        chk("t6_after_reset_idle", 32'(iss1_valid), 0);

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
